// File: rtl/axis_i2c_slave.sv
// I2C target bridging bus writes to an AXI-Stream master port and bus reads from an AXI-Stream slave port.
// Define AXIS_I2C_SLAVE_GCALL_EN to accept general-call (address 7'h00) writes.
module axis_i2c_slave #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h50,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk_i,
    input  logic       arstn_i,
    input  logic       en_i,
    input  logic       i2c_scl_i,
    inout  wire        i2c_sda_io,
    output logic [7:0] m_axis_tdata,
    output logic       m_axis_tvalid,
    input  logic       m_axis_tready,
    input  logic [7:0] s_axis_tdata,
    input  logic       s_axis_tvalid,
    output logic       s_axis_tready,
    output logic       busy_o
);

    localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WR_DATA,
        WR_ACK,
        RD_DATA,
        RD_ACK,
        IGNORE
    } state_t;

    state_t            state;
    logic [STAGES-1:0] scl_sync;
    logic [STAGES-1:0] sda_sync;
    logic              scl_q;
    logic              sda_q;
    logic              scl_s;
    logic              sda_s;
    logic              sda_pin;
    logic              sda_low;
    logic              scl_rise;
    logic              scl_fall;
    logic              start_det;
    logic              stop_det;
    logic [3:0]        bit_cnt;
    logic [6:0]        shift_reg;
    logic [6:0]        tx_shift;
    logic              rw_bit;
    logic              ack_phase;
    logic              ack_ok;
    logic [7:0]        rx_byte;
    logic [7:0]        tx_load;
    logic              addr_match;

    // Open-drain: the pad is only ever pulled low or released.
    assign i2c_sda_io = sda_low ? 1'b0 : 1'bz;
    assign sda_pin    = i2c_sda_io;

    assign scl_s     = scl_sync[STAGES-1];
    assign sda_s     = sda_sync[STAGES-1];
    assign scl_rise  = scl_s & ~scl_q;
    assign scl_fall  = ~scl_s & scl_q;
    assign start_det = scl_s & scl_q & sda_q & ~sda_s;
    assign stop_det  = scl_s & scl_q & ~sda_q & sda_s;

    assign rx_byte = {shift_reg, sda_s};
    assign tx_load = s_axis_tvalid ? s_axis_tdata : 8'hFF;

    // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        addr_match = (rx_byte[7:1] == SLAVE_ADDR);
`ifdef AXIS_I2C_SLAVE_GCALL_EN
        if ((rx_byte[7:1] == 7'h00) && !rx_byte[0]) begin
            addr_match = 1'b1;
        end
`endif
    end

    // Synchronizers idle high so reset release never fabricates a START or STOP.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_q    <= 1'b1;
            sda_q    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[STAGES-2:0], i2c_scl_i};
            sda_sync <= {sda_sync[STAGES-2:0], sda_pin};
            scl_q    <= scl_s;
            sda_q    <= sda_s;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; later assignments in the block take priority.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state         <= IDLE;
            sda_low       <= 1'b0;
            bit_cnt       <= 4'd0;
            shift_reg     <= 7'h00;
            tx_shift      <= 7'h7F;
            rw_bit        <= 1'b0;
            ack_phase     <= 1'b0;
            ack_ok        <= 1'b0;
            m_axis_tdata  <= 8'h00;
            m_axis_tvalid <= 1'b0;
            s_axis_tready <= 1'b0;
            busy_o        <= 1'b0;
        end else begin
            s_axis_tready <= 1'b0;
            if (m_axis_tvalid && m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end

            if (!en_i || stop_det) begin
                state     <= IDLE;
                sda_low   <= 1'b0;
                busy_o    <= 1'b0;
                bit_cnt   <= 4'd0;
                ack_phase <= 1'b0;
            end else if (start_det) begin
                state     <= ADDR;
                sda_low   <= 1'b0;
                bit_cnt   <= 4'd0;
                ack_phase <= 1'b0;
            end else begin
                case (state)
                    IDLE, IGNORE: begin
                        sda_low <= 1'b0;
                    end

                    ADDR: begin
                        if (scl_rise) begin
                            shift_reg <= rx_byte[6:0];
                            bit_cnt   <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd7) begin
                                bit_cnt <= 4'd0;
                                rw_bit  <= rx_byte[0];
                                if (addr_match) begin
                                    state  <= ADDR_ACK;
                                    busy_o <= 1'b1;
                                end else begin
                                    state  <= IGNORE;
                                    busy_o <= 1'b0;
                                end
                            end
                        end
                    end

                    // First fall opens the ACK bit, second fall closes it.
                    ADDR_ACK: begin
                        if (scl_fall) begin
                            if (!ack_phase) begin
                                ack_phase <= 1'b1;
                                sda_low   <= 1'b1;
                            end else begin
                                ack_phase <= 1'b0;
                                if (rw_bit) begin
                                    state         <= RD_DATA;
                                    tx_shift      <= tx_load[6:0];
                                    sda_low       <= ~tx_load[7];
                                    s_axis_tready <= s_axis_tvalid;
                                end else begin
                                    state   <= WR_DATA;
                                    sda_low <= 1'b0;
                                end
                            end
                        end
                    end

                    WR_DATA: begin
                        if (scl_rise) begin
                            shift_reg <= rx_byte[6:0];
                            bit_cnt   <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd7) begin
                                bit_cnt <= 4'd0;
                                state   <= WR_ACK;
                                // A byte still waiting for tready is kept; the new one is refused.
                                if (!m_axis_tvalid || m_axis_tready) begin
                                    m_axis_tdata  <= rx_byte;
                                    m_axis_tvalid <= 1'b1;
                                    ack_ok        <= 1'b1;
                                end else begin
                                    ack_ok <= 1'b0;
                                end
                            end
                        end
                    end

                    WR_ACK: begin
                        if (scl_fall) begin
                            if (!ack_phase) begin
                                ack_phase <= 1'b1;
                                sda_low   <= ack_ok;
                            end else begin
                                ack_phase <= 1'b0;
                                sda_low   <= 1'b0;
                                state     <= WR_DATA;
                            end
                        end
                    end

                    RD_DATA: begin
                        if (scl_rise) begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall) begin
                            if (bit_cnt == 4'd8) begin
                                bit_cnt <= 4'd0;
                                sda_low <= 1'b0;
                                state   <= RD_ACK;
                            end else begin
                                sda_low  <= ~tx_shift[6];
                                tx_shift <= {tx_shift[5:0], 1'b1};
                            end
                        end
                    end

                    RD_ACK: begin
                        if (scl_rise) begin
                            if (sda_s) begin
                                state <= IGNORE;
                            end
                        end else if (scl_fall) begin
                            state         <= RD_DATA;
                            tx_shift      <= tx_load[6:0];
                            sda_low       <= ~tx_load[7];
                            s_axis_tready <= s_axis_tvalid;
                        end
                    end

                    default: begin
                        state   <= IDLE;
                        sda_low <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_axis_i2c_slave.sv
// Directed bench for axis_i2c_slave: a bit-banged I2C master plus AXIS monitors, checked by immediate assertions.
module tb_axis_i2c_slave;

    localparam int T = 200;

    logic       clk       = 1'b0;
    logic       arstn     = 1'b0;
    logic       en        = 1'b1;
    logic       scl       = 1'b1;
    logic       sda_m_low = 1'b0;
    wire        sda;
    logic [7:0] m_tdata;
    logic       m_tvalid;
    logic       m_tready  = 1'b0;
    logic [7:0] s_tdata   = 8'h00;
    logic       s_tvalid  = 1'b0;
    logic       s_tready;
    logic       busy;

    int         vectors     = 0;
    int         miscompares = 0;
    logic [7:0] rx_q[$];
    int         tready_pulses = 0;
    logic       tready_prev   = 1'b0;
    logic       tready_wide   = 1'b0;
    logic       dut_drove     = 1'b0;

    assign sda = sda_m_low ? 1'b0 : 1'bz;
    pullup (sda);

    always #5 clk = ~clk;

    axis_i2c_slave dut (
        .clk_i         (clk),
        .arstn_i       (arstn),
        .en_i          (en),
        .i2c_scl_i     (scl),
        .i2c_sda_io    (sda),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .busy_o        (busy)
    );

    always @(posedge clk) begin
        if (m_tvalid && m_tready) rx_q.push_back(m_tdata);
        if (s_tready && !tready_prev) tready_pulses++;
        if (s_tready && tready_prev) tready_wide = 1'b1;
        tready_prev = s_tready;
        if (!sda_m_low && sda === 1'b0) dut_drove = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic i2c_start();
        sda_m_low = 1'b0;
        #(T/2);
        if (!scl) begin
            scl = 1'b1;
            #(T/2);
        end
        sda_m_low = 1'b1;
        #(T/2);
        scl = 1'b0;
        #(T/2);
    endtask

    task automatic i2c_stop();
        #(T/2);
        sda_m_low = 1'b1;
        #(T/2);
        scl = 1'b1;
        #T;
        sda_m_low = 1'b0;
        #T;
    endtask

    task automatic write_bit(input logic b);
        #(T/2);
        sda_m_low = ~b;
        #(T/2);
        scl = 1'b1;
        #T;
        scl = 1'b0;
    endtask

    task automatic read_bit(output logic b);
        #(T/4);
        sda_m_low = 1'b0;
        #(3*T/4);
        scl = 1'b1;
        #(T/2);
        b = sda;
        #(T/2);
        scl = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] data, output logic ack_n);
        for (int i = 7; i >= 0; i--) write_bit(data[i]);
        read_bit(ack_n);
    endtask

    task automatic read_byte(output logic [7:0] data);
        for (int i = 7; i >= 0; i--) read_bit(data[i]);
    endtask

    initial begin
        logic       ack;
        logic [7:0] d;
        int         p0;

        repeat (3) @(posedge clk);
        #2;
        check("rst_m_tvalid", m_tvalid, 0);
        check("rst_m_tdata", m_tdata, 8'h00);
        check("rst_s_tready", s_tready, 0);
        check("rst_busy", busy, 0);
        check("rst_sda", sda, 1);
        arstn = 1'b1;
        repeat (5) @(posedge clk);
        #2;

        // Two-byte write to the matching address with the sink ready.
        m_tready = 1'b1;
        i2c_start();
        write_byte(8'hA0, ack); check("w_addr_ack", ack, 0);
        check("w_busy_mid", busy, 1);
        write_byte(8'hA5, ack); check("w_d0_ack", ack, 0);
        write_byte(8'h3C, ack); check("w_d1_ack", ack, 0);
        i2c_stop();
        check("w_busy_after", busy, 0);
        check("w_rx_count", rx_q.size(), 2);
        check("w_rx0", rx_q[0], 8'hA5);
        check("w_rx1", rx_q[1], 8'h3C);

        // Wrong address: never acknowledged, bus never pulled by the target.
        rx_q.delete();
        p0 = tready_pulses;
        dut_drove = 1'b0;
        i2c_start();
        write_byte(8'hA2, ack); check("miss_addr_nack", ack, 1);
        write_byte(8'h55, ack); check("miss_data_nack", ack, 1);
        i2c_stop();
        check("miss_sda_driven", dut_drove, 0);
        check("miss_rx_count", rx_q.size(), 0);
        check("miss_tready", tready_pulses - p0, 0);
        check("miss_busy", busy, 0);

        // Two-byte read fed from s_axis, master ACKs then NACKs.
        p0 = tready_pulses;
        tready_wide = 1'b0;
        s_tvalid = 1'b1;
        s_tdata = 8'h12;
        i2c_start();
        write_byte(8'hA1, ack); check("r_addr_ack", ack, 0);
        read_byte(d);
        s_tdata = 8'h34;
        write_bit(1'b0);
        check("r_d0", d, 8'h12);
        read_byte(d);
        s_tvalid = 1'b0;
        write_bit(1'b1);
        check("r_d1", d, 8'h34);
        i2c_stop();
        check("r_tready_pulses", tready_pulses - p0, 2);
        check("r_tready_width", tready_wide, 0);
        check("r_busy_after", busy, 0);

        // Read with nothing offered returns all ones and no handshake.
        p0 = tready_pulses;
        i2c_start();
        write_byte(8'hA1, ack); check("rff_addr_ack", ack, 0);
        read_byte(d);
        write_bit(1'b1);
        i2c_stop();
        check("rff_data", d, 8'hFF);
        check("rff_tready", tready_pulses - p0, 0);

        // Sink stalled: first byte held, second refused.
        m_tready = 1'b0;
        rx_q.delete();
        i2c_start();
        write_byte(8'hA0, ack); check("bp_addr_ack", ack, 0);
        write_byte(8'h11, ack); check("bp_d0_ack", ack, 0);
        write_byte(8'h22, ack); check("bp_d1_nack", ack, 1);
        i2c_stop();
        check("bp_tvalid_held", m_tvalid, 1);
        check("bp_tdata_held", m_tdata, 8'h11);
        m_tready = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check("bp_rx_count", rx_q.size(), 1);
        check("bp_rx0", rx_q[0], 8'h11);
        check("bp_tvalid_clr", m_tvalid, 0);

        // Enable dropped mid-transfer: abort, keep the pending byte.
        m_tready = 1'b0;
        rx_q.delete();
        i2c_start();
        write_byte(8'hA0, ack); check("en_addr_ack", ack, 0);
        write_byte(8'h42, ack); check("en_d0_ack", ack, 0);
        en = 1'b0;
        #30;
        check("en_busy", busy, 0);
        check("en_tvalid_kept", m_tvalid, 1);
        check("en_tdata_kept", m_tdata, 8'h42);
        en = 1'b1;
        write_byte(8'h66, ack); check("en_after_nack", ack, 1);
        i2c_stop();
        m_tready = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check("en_rx_count", rx_q.size(), 1);

        // Reset pulse in the middle of a data byte with a held output byte.
        m_tready = 1'b0;
        i2c_start();
        write_byte(8'hA0, ack); check("rs_addr_ack", ack, 0);
        write_byte(8'h99, ack); check("rs_d0_ack", ack, 0);
        i2c_start();
        write_byte(8'hA0, ack); check("rs_rstart_ack", ack, 0);
        write_bit(1'b1);
        write_bit(1'b1);
        write_bit(1'b1);
        arstn = 1'b0;
        #20;
        check("rs_m_tvalid", m_tvalid, 0);
        check("rs_m_tdata", m_tdata, 8'h00);
        check("rs_busy", busy, 0);
        check("rs_s_tready", s_tready, 0);
        check("rs_sda", sda, 1);
        arstn = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        for (int i = 0; i < 5; i++) write_bit(1'b0);
        read_bit(ack); check("rs_no_ack_without_start", ack, 1);
        i2c_stop();
        m_tready = 1'b1;
        rx_q.delete();
        i2c_start();
        write_byte(8'hA0, ack); check("rs_new_addr_ack", ack, 0);
        write_byte(8'h77, ack); check("rs_new_d0_ack", ack, 0);
        i2c_stop();
        check("rs_new_rx_count", rx_q.size(), 1);
        check("rs_new_rx0", rx_q[0], 8'h77);

        // General call write and read.
        rx_q.delete();
        i2c_start();
        write_byte(8'h00, ack);
`ifdef AXIS_I2C_SLAVE_GCALL_EN
        check("gc_w_ack", ack, 0);
        write_byte(8'h5A, ack); check("gc_d0_ack", ack, 0);
        i2c_stop();
        check("gc_rx_count", rx_q.size(), 1);
        check("gc_rx0", rx_q[0], 8'h5A);
`else
        check("gc_w_nack", ack, 1);
        write_byte(8'h5A, ack); check("gc_d0_nack", ack, 1);
        i2c_stop();
        check("gc_rx_count", rx_q.size(), 0);
`endif
        i2c_start();
        write_byte(8'h01, ack); check("gc_r_nack", ack, 1);
        i2c_stop();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
